// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// State encoding, counter sizing and the 1-bit full-subtract cell live here.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit counter width: clog2(WIDTH/DIGIT), never narrower than one bit.
    function automatic int cnt_width(input int width, input int digit);
        int w;
        w = $clog2(width / digit);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

    // One full-subtract cell, returns {borrow_out, diff}.
    function automatic logic [1:0] fs_cell(input logic a, input logic b, input logic bin);
        return {((~a) & b) | ((~(a ^ b)) & bin), a ^ b ^ bin};
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit ripple subtractor built from full-subtract cells.
module sub_digit
    import serial_subtractor_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic       br_s;
    logic [1:0] cell_s;

    // Ripple the borrow from the LSB cell up through the digit.
    always_comb begin
        br_s   = bin;
        cell_s = 2'b00;
        d      = {DIGIT{1'b0}};
        for (int i = 0; i < DIGIT; i++) begin
            cell_s = fs_cell(a[i], b[i], br_s);
            d[i]   = cell_s[0];
            br_s   = cell_s[1];
        end
        bout = br_s;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - borrow_in, DIGIT bits per clock, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds a two's-complement overflow_out flag.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             borrow_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,output logic             overflow_out
`endif
);

    localparam int CW = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH / DIGIT - 1);

    generate
        if ((WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
            $error("serial_subtractor: WIDTH must be >= 2 and divisible by DIGIT");
        end
    endgenerate

    state_t           state_r, state_nxt_s;
    logic             accept_s, last_s;
    logic [WIDTH-1:0] a_r, b_r, res_r, res_nxt_s;
    logic             borrow_r;
    logic [CW-1:0]    cnt_r;
    logic [DIGIT-1:0] dig_d_s;
    logic             dig_bout_s;
    logic             ready_r, busy_r, done_r, borrow_out_r;
    logic [WIDTH-1:0] diff_r;

    sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
        .a    (a_r[DIGIT-1:0]),
        .b    (b_r[DIGIT-1:0]),
        .bin  (borrow_r),
        .d    (dig_d_s),
        .bout (dig_bout_s)
    );

    // New difference bits enter at the MSB end of the result register.
    generate
        if (DIGIT == WIDTH) begin : g_res_full
            assign res_nxt_s = dig_d_s;
        end else begin : g_res_shift
            assign res_nxt_s = {dig_d_s, res_r[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Next-state decode; start is only honoured while not running.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_in) begin
                    state_nxt_s = ST_RUN;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = ST_DONE;
                    last_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register with registered handshake flags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s != ST_RUN);
            busy_r  <= (state_nxt_s == ST_RUN);
        end
    end

    // Operand/result shift registers and digit counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            res_r    <= {WIDTH{1'b0}};
            borrow_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else if (accept_s) begin
            a_r      <= a_in;
            b_r      <= b_in;
            res_r    <= {WIDTH{1'b0}};
            borrow_r <= borrow_in;
            cnt_r    <= {CW{1'b0}};
        end else if (state_r == ST_RUN) begin
            a_r      <= a_r >> DIGIT;
            b_r      <= b_r >> DIGIT;
            res_r    <= res_nxt_s;
            borrow_r <= dig_bout_s;
            cnt_r    <= cnt_r + CW'(1);
        end
    end

    // Result outputs load only on the final digit and are held otherwise.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            done_r       <= 1'b0;
            diff_r       <= {WIDTH{1'b0}};
            borrow_out_r <= 1'b0;
        end else begin
            done_r <= last_s;
            if (last_s) begin
                diff_r       <= res_nxt_s;
                borrow_out_r <= dig_bout_s;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic sign_a_r, sign_b_r, ovf_r;

    // Operand signs are kept because the shift registers lose them.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                sign_a_r <= a_in[WIDTH-1];
                sign_b_r <= b_in[WIDTH-1];
            end
            if (last_s) begin
                ovf_r <= (sign_a_r != sign_b_r) && (res_nxt_s[WIDTH-1] != sign_a_r);
            end
        end
    end

    assign overflow_out = ovf_r;
`endif

    assign ready_out  = ready_r;
    assign busy_out   = busy_r;
    assign done_out   = done_r;
    assign diff_out   = diff_r;
    assign borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (8/1 with a cycle model, 16/4 directed).
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a, b;
    logic        bin;
    logic        ready_out, busy_out, done_out, borrow_out;
    logic [7:0]  diff_out;

    logic        s16;
    logic [15:0] a16, b16;
    logic        bin16;
    logic        ready16, busy16, done16, borrow16;
    logic [15:0] diff16;

`ifdef SERIAL_SUB_OVF_EN
    logic        ovf8, ovf16;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .a_in(a), .b_in(b), .borrow_in(bin),
        .ready_out(ready_out), .busy_out(busy_out), .done_out(done_out),
        .diff_out(diff_out), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
       ,.overflow_out(ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk_in(clk), .rst_in(rst), .start_in(s16),
        .a_in(a16), .b_in(b16), .borrow_in(bin16),
        .ready_out(ready16), .busy_out(busy16), .done_out(done16),
        .diff_out(diff16), .borrow_out(borrow16)
`ifdef SERIAL_SUB_OVF_EN
       ,.overflow_out(ovf16)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic: {borrow, diff} of the unsigned subtraction.
    function automatic logic [8:0] model_full(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - {8'd0, c};
    endfunction

    function automatic logic model_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] f;
        f = model_full(x, y, c);
        return (x[7] != y[7]) && (f[7] != x[7]);
    endfunction

    // Cycle model: countdown of busy cycles, result published when it expires.
    int         m_rem = 0;
    logic       m_valid = 1'b0;
    logic       m_done, m_borrow, m_ovf, p_ovf;
    logic [7:0] m_diff;
    logic [8:0] p_full;

    always @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b1;
            m_rem    <= 0;
            m_done   <= 1'b0;
            m_diff   <= 8'h00;
            m_borrow <= 1'b0;
            m_ovf    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 1) begin
                m_rem    <= 0;
                m_done   <= 1'b1;
                m_diff   <= p_full[7:0];
                m_borrow <= p_full[8];
                m_ovf    <= p_ovf;
            end else if (m_rem > 1) begin
                m_rem <= m_rem - 1;
            end else if (start) begin
                p_full <= model_full(a, b, bin);
                p_ovf  <= model_ovf(a, b, bin);
                m_rem  <= 8;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_ready",  ready_out,  m_rem == 0);
            chk("m_busy",   busy_out,   m_rem != 0);
            chk("m_done",   done_out,   m_done);
            chk("m_diff",   diff_out,   m_diff);
            chk("m_borrow", borrow_out, m_borrow);
`ifdef SERIAL_SUB_OVF_EN
            chk("m_ovf",    ovf8,       m_ovf);
`endif
        end
    end

    task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic c);
        @(posedge clk); #1;
        a = x; b = y; bin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int bc);
        bit seen;
        bc = 0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (done_out) seen = 1'b1;
            else if (busy_out) bc++;
        end
        chk("done_timeout", seen, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bc;
        bit  seen;
        rst = 1'b1; start = 1'b1; a = 8'h00; b = 8'h00; bin = 1'b0;
        s16 = 1'b1; a16 = 16'h0000; b16 = 16'h0000; bin16 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready_out, 1'b1);
        chk("rst_busy",  busy_out,  1'b0);
        chk("rst_done",  done_out,  1'b0);
        chk("rst_diff",  diff_out,  8'h00);
        chk("rst_borrow", borrow_out, 1'b0);
        rst = 1'b0; start = 1'b0; s16 = 1'b0;

        start_op(8'h5A, 8'h23, 1'b0);
        wait_done(bc);
        chk("basic_busy", bc, 8);
        chk("basic_diff", diff_out, 8'h37);
        chk("basic_borrow", borrow_out, 1'b0);

        start_op(8'h10, 8'h20, 1'b1);
        wait_done(bc);
        chk("under_diff", diff_out, 8'hEF);
        chk("under_borrow", borrow_out, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
        chk("under_ovf", ovf8, 1'b0);
`endif

        start_op(8'h80, 8'h01, 1'b0);
        wait_done(bc);
        chk("ovf_diff", diff_out, 8'h7F);
        chk("ovf_borrow", borrow_out, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf_flag", ovf8, 1'b1);
`endif

        // Mid-run start must be ignored; start in DONE must be taken at once.
        start_op(8'hF0, 8'h0F, 1'b0);
        repeat (2) @(posedge clk);
        #1; a = 8'h00; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(bc);
        chk("hs_first_diff", diff_out, 8'hE1);
        chk("hs_first_borrow", borrow_out, 1'b0);
        a = 8'h01; b = 8'h02; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("hs_b2b_busy", busy_out, 1'b1);
        chk("hs_hold_diff", diff_out, 8'hE1);
        wait_done(bc);
        chk("hs_second_busy", bc, 7);
        chk("hs_second_diff", diff_out, 8'hFF);
        chk("hs_second_borrow", borrow_out, 1'b1);

        // Abort in the third RUN cycle.
        start_op(8'h5A, 8'h23, 1'b0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", ready_out, 1'b1);
        chk("abort_busy", busy_out, 1'b0);
        chk("abort_diff", diff_out, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_out) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);

        // Wide operands, four bits per cycle.
        @(posedge clk); #1;
        a16 = 16'h1234; b16 = 16'h4321; bin16 = 1'b0; s16 = 1'b1;
        @(posedge clk); #1; s16 = 1'b0;
        bc = 0; seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (done16) seen = 1'b1;
            else if (busy16) bc++;
        end
        chk("w16_done", seen, 1'b1);
        chk("w16_busy", bc, 4);
        chk("w16_diff", diff16, 16'hCF13);
        chk("w16_borrow", borrow16, 1'b1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
